// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared multiplier FSM state encodings and default operand width
package mips_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one radix-2 shift-add step of the HI/LO multiplier
module mult_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic               mplier_lsb_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] upper_sum;

  // Add the multiplicand into the upper half when the current multiplier bit
  // is set, then shift the carry-extended accumulator right by one.
  always_comb begin
    upper_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    if (mplier_lsb_i) begin
      upper_sum = upper_sum + {1'b0, mcand_i};
    end
    acc_o = {upper_sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_ctrl.sv
// rtl/mult_ctrl.sv - multi-cycle MULTU/MULT unit with HI/LO and MF stall (MULT_SIGNED_EN adds is_signed)
module mult_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             mf_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q;
  logic                 accept;

  assign accept = start && (state_q != ST_RUN);

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_i        (acc_q),
    .mcand_i      (mcand_q),
    .mplier_lsb_i (mplier_q[0]),
    .acc_o        (acc_d)
  );

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic a_neg, b_neg;

  // Signed multiplies run on magnitudes; the sign is reapplied to the final product.
  always_comb begin
    a_neg    = is_signed && operand_a[WIDTH-1];
    b_neg    = is_signed && operand_b[WIDTH-1];
    mcand_d  = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
    mplier_d = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;
    neg_d    = a_neg ^ b_neg;
    prod_d   = neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
  end

  // Sign of the result, captured alongside the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_d;
    end
  end
`else
  // Unsigned-only build: operands and product pass straight through.
  always_comb begin
    mcand_d  = operand_a;
    mplier_d = operand_b;
    prod_d   = acc_d;
  end
`endif

  // Control FSM: operand capture, WIDTH shift-add cycles, HI/LO update on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            state_q  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // HI/LO are valid in DONE, so only an in-flight multiply stalls MFHI/MFLO.
  assign stall = mf_req && (state_q == ST_RUN);
  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// tb/tb_mult_ctrl.sv - randomized self-checking bench for mult_ctrl against an arithmetic product model
module tb_mult_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         mf_req;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;
`ifdef MULT_SIGNED_EN
  logic         is_signed;
`endif

  bit sgn_mode = 1'b0;
  int n_tests  = 0;
  int n_fail   = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
`ifdef MULT_SIGNED_EN
    .is_signed (is_signed),
`endif
    .mf_req    (mf_req),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
`ifdef MULT_SIGNED_EN
    is_signed = sgn_mode;
`endif
    tick();
    start     = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int glitch_at, output int lat, output int stalls);
    lat    = 0;
    stalls = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (stall === 1'b1) stalls++;
      if (lat == glitch_at) begin
        start     = 1'b1;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      tick();
      start = 1'b0;
      lat++;
    end
  endtask

  // Runs one multiply with mf_req held; returns in the DONE cycle.
  task automatic full_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at, input bit chk_hold, input logic [63:0] prev);
    int lat, stalls;
    logic [63:0] exp;
    exp    = ref_prod(a, b, sgn_mode);
    mf_req = 1'b1;
    launch(a, b);
    if (chk_hold) chk({tag, "_hold"}, {hi, lo}, prev);
    wait_done(glitch_at, lat, stalls);
    chk({tag, "_latency"}, 64'(lat), 64'(W));
    chk({tag, "_stalls"}, 64'(stalls), 64'(W));
    chk({tag, "_stall_done"}, 64'(stall), 64'd0);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_prod"}, {hi, lo}, exp);
  endtask

  task automatic idle_check(input string tag);
    tick();
    chk({tag, "_done_once"}, 64'(done), 64'd0);
    chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
    chk({tag, "_stall_idle"}, 64'(stall), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] p1;
    int          dones;
    int          g;

    reset     = 1'b1;
    start     = 1'b0;
    mf_req    = 1'b1;
    operand_a = '0;
    operand_b = '0;
`ifdef MULT_SIGNED_EN
    is_signed = 1'b0;
`endif
    tick();
    tick();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    tick();

    full_mul("a3b5", 32'd3, 32'd5, -1, 1'b0, 64'd0);
    chk("a3b5_hi", 64'(hi), 64'h0);
    chk("a3b5_lo", 64'(lo), 64'hF);
    idle_check("a3b5");

    full_mul("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 64'd0);
    chk("ones_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("ones_lo", 64'(lo), 64'h0000_0001);
    idle_check("ones");

    full_mul("zero", 32'd0, 32'h1234_5678, -1, 1'b0, 64'd0);
    chk("zero_hilo", {hi, lo}, 64'd0);
    idle_check("zero");

    full_mul("glitch", 32'd7, 32'd9, 5, 1'b0, 64'd0);
    chk("glitch_lo", 64'(lo), 64'd63);
    idle_check("glitch");

    full_mul("b2b_first", 32'hDEAD_BEEF, 32'h0000_1003, -1, 1'b0, 64'd0);
    p1 = ref_prod(32'hDEAD_BEEF, 32'h0000_1003, 1'b0);
    full_mul("b2b_second", 32'h8000_0001, 32'h7FFF_FFFF, -1, 1'b1, p1);
    idle_check("b2b");

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFF_FFFF;
        1:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
      full_mul($sformatf("rnd%0d", i), ra, rb, g, 1'b0, 64'd0);
      idle_check($sformatf("rnd%0d", i));
    end

    full_mul("pre_rst", 32'h0000_1234, 32'h0000_5678, -1, 1'b0, 64'd0);
    idle_check("pre_rst");
    launch(32'd3, 32'd5);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    chk("midrst_hilo_hold", {hi, lo}, 64'd0);

`ifdef MULT_SIGNED_EN
    sgn_mode = 1'b1;
    full_mul("sgn_m2x3", 32'hFFFF_FFFE, 32'd3, -1, 1'b0, 64'd0);
    chk("sgn_m2x3_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("sgn_m2x3_lo", 64'(lo), 64'hFFFF_FFFA);
    idle_check("sgn_m2x3");
    for (int i = 0; i < 4; i++) begin
      full_mul($sformatf("sgn_rnd%0d", i), $urandom, $urandom, -1, 1'b0, 64'd0);
      idle_check($sformatf("sgn_rnd%0d", i));
    end
    sgn_mode = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  MULTU issued from execute stage; sampled only when accepted (REQ-010).
REQ-005 SHALL have port operand_a  input  WIDTH  multiplicand, captured on accepted start.
REQ-006 SHALL have port operand_b  input  WIDTH  multiplier, captured on accepted start.
REQ-007 SHALL have port mf_req  input  1  MFHI/MFLO present in execute stage.
REQ-008 SHALL have ports busy, done, stall  output  1 each; hi, lo  output  WIDTH each (architectural HI/LO).

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE.
REQ-010 SHALL accept start only in IDLE or DONE; on acceptance capture operands, clear 2*WIDTH accumulator, clear counter, go to RUN.
REQ-011 SHALL ignore start while in RUN (no operand capture, no restart).
REQ-012 In RUN SHALL perform one radix-2 shift-add step per cycle: if multiplier LSB is 1, add multiplicand to the upper WIDTH bits with carry out; shift {carry, acc} right by one.
REQ-013 SHALL stay in RUN exactly WIDTH cycles (counter 0..WIDTH-1), then enter DONE.
REQ-014 On entry to DONE SHALL load hi/lo from the accumulator upper/lower halves; hi/lo SHALL hold otherwise.
REQ-015 SHALL assert done for exactly one cycle, while in DONE; DONE returns to IDLE next cycle unless start is accepted.
REQ-016 SHALL assert busy exactly while in RUN.
REQ-017 SHALL assert stall combinationally when mf_req=1 and state is RUN; stall=0 otherwise, including in DONE, because hi/lo are valid there.
REQ-018 Total latency: start accepted at edge k leads to done=1 in the cycle after edge k+WIDTH.
REQ-019 Back-to-back: start in DONE cycle SHALL launch the next multiply with no idle gap; hi/lo keep the previous result until the next DONE.
REQ-020 Product SHALL be exact unsigned 2*WIDTH bits; no overflow detection.

Reset
REQ-021 reset SHALL force IDLE and clear counter, accumulator and operand registers, with hi=0, lo=0, busy=0, done=0.
REQ-022 reset SHALL take priority over start; reset mid-RUN SHALL abandon the operation with no hi/lo update.
REQ-023 stall SHALL be 0 in the cycle following reset.

Configuration
REQ-024 With MULT_SIGNED_EN defined SHALL add input is_signed (1 bit, captured with operands) supporting MULT.
REQ-025 is_signed=1 SHALL multiply the absolute values and negate the 2*WIDTH result in DONE when the operand signs differ; latency is unchanged.
REQ-026 Without MULT_SIGNED_EN SHALL have no is_signed port; all multiplies are unsigned.

Structure
REQ-027 FSM state encodings (IDLE=0, RUN=1, DONE=2) and the default WIDTH SHALL reside in shared package mips_pkg.
REQ-028 Shift-add step (adder, carry, shift) SHALL be sub-module mult_step; the FSM, counter and HI/LO registers SHALL remain in mult_ctrl.

Verification
REQ-029 start, a=3, b=5 -> done after 32 RUN cycles; hi=0x00000000, lo=0x0000000F.
REQ-030 a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a=0, b=0x12345678 -> hi=lo=0.
REQ-031 mf_req held from start+1 -> stall=1 for exactly 32 cycles, 0 in the DONE cycle.
REQ-032 start pulsed mid-RUN with new operands -> ignored; first result still correct. start in DONE -> second result 32 cycles later.
REQ-033 reset at RUN cycle 10 -> next cycle IDLE, busy=0, hi=lo=0, no done pulse.
REQ-034 MULT_SIGNED_EN, is_signed=1, a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
